// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared encodings for the pipeline hazard unit
package hazard_unit_pkg;

    localparam int FWD_RF = 0;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination shift register with per-stage match/ready flags
module hazard_scoreboard
    import hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_W      = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [REG_W-1:0]      push_rd,
    input  logic                  push_load,
    input  logic [REG_W-1:0]      rs,
    input  logic [REG_W-1:0]      rt,
    output logic [NUM_STAGES-1:0] match_a,
    output logic [NUM_STAGES-1:0] match_b,
    output logic [NUM_STAGES-1:0] ready
);

    logic [NUM_STAGES-1:0] vld;
    logic [NUM_STAGES-1:0] ld;
    logic [REG_W-1:0]      rd [NUM_STAGES];

    // entries age one stage per cycle; index 0 is stage 1 and takes the issuing instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            ld  <= '0;
            for (int k = 0; k < NUM_STAGES; k++) rd[k] <= '0;
        end else begin
            vld[0] <= push;
            ld[0]  <= push_load;
            rd[0]  <= push_rd;
            for (int k = 1; k < NUM_STAGES; k++) begin
                vld[k] <= vld[k-1];
                ld[k]  <= ld[k-1];
                rd[k]  <= rd[k-1];
            end
        end
    end

    // register 0 never matches; load data is usable only beyond LOAD_LAT stages
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            match_a[k] = vld[k] && rd[k] == rs && rs != '0;
            match_b[k] = vld[k] && rd[k] == rt && rt != '0;
            ready[k]   = !ld[k] || (k + 1 > LOAD_LAT);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: bypass selection, load-use stall and redirect/reset flush control
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter  int NUM_STAGES   = 2,
    parameter  int REG_W        = 5,
    parameter  int LOAD_LAT     = 1,
    parameter  int FLUSH_CYCLES = 3,
    parameter  int REDIR_SHADOW = 1,
    localparam int SEL_W        = sel_w(NUM_STAGES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_is_load,
    input  logic             redirect,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic             stall,
    output logic             flush,
    output logic             pipe_ready
);

    localparam int CNT_MAX = FLUSH_CYCLES > REDIR_SHADOW ? FLUSH_CYCLES : REDIR_SHADOW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [NUM_STAGES-1:0] match_a, match_b, ready;
    logic                  hazard_a, hazard_b, push;

    assign push = id_valid && pipe_ready && !stall && !flush && id_wr_en && id_rd != '0;

    hazard_scoreboard #(
        .NUM_STAGES(NUM_STAGES),
        .REG_W     (REG_W),
        .LOAD_LAT  (LOAD_LAT)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_rd  (id_rd),
        .push_load(id_is_load),
        .rs       (id_rs),
        .rt       (id_rt),
        .match_a  (match_a),
        .match_b  (match_b),
        .ready    (ready)
    );

    // state and shared INIT/FLUSH counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
            cnt   <= CNT_W'(FLUSH_CYCLES);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // INIT and FLUSH count down to 1 then fall into RUN; a redirect (re)loads the shadow count
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == ST_INIT) begin
            state_nx = cnt == CNT_W'(1) ? ST_RUN : ST_INIT;
            cnt_nx   = cnt - CNT_W'(1);
        end else if (redirect && REDIR_SHADOW > 1) begin
            state_nx = ST_FLUSH;
            cnt_nx   = CNT_W'(REDIR_SHADOW - 1);
        end else if (state == ST_FLUSH) begin
            state_nx = cnt == CNT_W'(1) ? ST_RUN : ST_FLUSH;
            cnt_nx   = cnt - CNT_W'(1);
        end
    end

    // youngest matching stage wins; a load not yet ready at that stage becomes a hazard
    always_comb begin
        fwd_sel_a = SEL_W'(FWD_RF);
        fwd_sel_b = SEL_W'(FWD_RF);
        hazard_a  = 1'b0;
        hazard_b  = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (match_a[k-1]) begin
                fwd_sel_a = ready[k-1] ? SEL_W'(k) : SEL_W'(FWD_RF);
                hazard_a  = !ready[k-1];
            end
            if (match_b[k-1]) begin
                fwd_sel_b = ready[k-1] ? SEL_W'(k) : SEL_W'(FWD_RF);
                hazard_b  = !ready[k-1];
            end
        end
        if (!id_use_rs) begin
            fwd_sel_a = SEL_W'(FWD_RF);
            hazard_a  = 1'b0;
        end
        if (!id_use_rt) begin
            fwd_sel_b = SEL_W'(FWD_RF);
            hazard_b  = 1'b0;
        end
    end

    // INIT forces stall+flush; in operation a redirect flushes and overrides any load-use stall
    always_comb begin
        pipe_ready = state != ST_INIT;
        flush      = state != ST_RUN || redirect;
        stall      = !pipe_ready || (id_valid && (hazard_a || hazard_b) && !redirect);
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard-driven check of two hazard_unit instances (REDIR_SHADOW 1 and 2)
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, redirect;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic       st0, fl0, rdy0, st1, fl1, rdy1;
    logic [13:0] obs;
    logic [13:0] sb [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign obs = {fa0, fb0, st0, fl0, rdy0, fa1, fb1, st1, fl1, rdy1};

    hazard_unit #(.REDIR_SHADOW(1)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .redirect(redirect), .fwd_sel_a(fa0), .fwd_sel_b(fb0),
        .stall(st0), .flush(fl0), .pipe_ready(rdy0)
    );

    hazard_unit #(.REDIR_SHADOW(2)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .redirect(redirect), .fwd_sel_a(fa1), .fwd_sel_b(fb1),
        .stall(st1), .flush(fl1), .pipe_ready(rdy1)
    );

    function automatic logic [20:0] mk(int v, int rs, int rt, int urs, int urt, int wr, int rd, int ld);
        return {1'(v), 5'(rs), 5'(rt), 1'(urs), 1'(urt), 1'(wr), 5'(rd), 1'(ld), 1'b0};
    endfunction

    function automatic logic [20:0] addu(int d, int s, int t);
        return mk(1, s, t, 1, 1, 1, d, 0);
    endfunction

    function automatic logic [20:0] lw(int t, int b);
        return mk(1, b, t, 1, 0, 1, t, 1);
    endfunction

    function automatic logic [20:0] ori(int t, int s);
        return mk(1, s, t, 1, 0, 1, t, 0);
    endfunction

    function automatic logic [20:0] nop();
        return addu(0, 0, 0);
    endfunction

    function automatic logic [20:0] rdr(logic [20:0] s);
        return s | 21'd1;
    endfunction

    function automatic logic [6:0] ex(int a, int b, int st, int fl, int rdy);
        return {2'(a), 2'(b), 1'(st), 1'(fl), 1'(rdy)};
    endfunction

    function automatic logic [13:0] both(logic [6:0] x);
        return {x, x};
    endfunction

    task automatic drive(input logic [20:0] s);
        {id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd, id_is_load, redirect} = s;
    endtask

    task automatic test_reset();
        logic [20:0] s [4];
        logic [13:0] x [4];
        logic [13:0] e;
        reset = 1'b0;
        drive(nop());
        sb.push_back(both(ex(0, 0, 1, 1, 0)));
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        reset = 1'b1;
        s = '{nop(), nop(), nop(), nop()};
        x = '{both(ex(0, 0, 1, 1, 0)), both(ex(0, 0, 1, 1, 0)), both(ex(0, 0, 1, 1, 0)),
              both(ex(0, 0, 0, 0, 1))};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL reset_init[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fwd();
        logic [20:0] s [9];
        logic [13:0] x [9];
        logic [13:0] e;
        s = '{addu(5, 1, 2), addu(6, 5, 5), addu(5, 1, 2), nop(), addu(6, 5, 5),
              addu(5, 1, 2), nop(), nop(), addu(6, 5, 5)};
        x = '{both(ex(0, 0, 0, 0, 1)), both(ex(1, 1, 0, 0, 1)), both(ex(0, 0, 0, 0, 1)),
              both(ex(0, 0, 0, 0, 1)), both(ex(2, 2, 0, 0, 1)), both(ex(0, 0, 0, 0, 1)),
              both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 0, 1))};
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL fwd[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [20:0] s [4];
        logic [13:0] x [4];
        logic [13:0] e;
        s = '{lw(7, 1), addu(8, 7, 1), addu(8, 7, 1), addu(9, 8, 7)};
        x = '{both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 1, 0, 1)), both(ex(2, 0, 0, 0, 1)),
              both(ex(1, 0, 0, 0, 1))};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL load_use[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_youngest();
        logic [20:0] s [3];
        logic [13:0] x [3];
        logic [13:0] e;
        s = '{addu(9, 1, 1), addu(10, 9, 0), addu(11, 1, 9)};
        x = '{both(ex(0, 0, 0, 0, 1)), both(ex(1, 0, 0, 0, 1)), both(ex(0, 2, 0, 0, 1))};
        for (int i = 0; i < 3; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL youngest[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_and_imm();
        logic [20:0] s [7];
        logic [13:0] x [7];
        logic [13:0] e;
        s = '{addu(0, 1, 1), addu(2, 0, 0), lw(0, 3), addu(4, 0, 0), ori(4, 1), lw(13, 1), ori(13, 2)};
        x = '{both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 0, 1)),
              both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 0, 1)),
              both(ex(0, 0, 0, 0, 1))};
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL zero_imm[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [20:0] s [4];
        logic [13:0] x [4];
        logic [13:0] e;
        s = '{lw(14, 1), rdr(addu(15, 14, 1)), addu(15, 14, 1), nop()};
        x = '{both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 1, 1)),
              {ex(2, 0, 0, 0, 1), ex(2, 0, 0, 1, 1)}, both(ex(0, 0, 0, 0, 1))};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL redirect[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_shadow();
        logic [20:0] s [9];
        logic [13:0] x [9];
        logic [13:0] e;
        s = '{nop(), rdr(nop()), nop(), nop(), rdr(nop()), rdr(nop()), nop(), addu(16, 1, 1), rdr(nop())};
        x = '{both(ex(0, 0, 0, 0, 1)), both(ex(0, 0, 0, 1, 1)),
              {ex(0, 0, 0, 0, 1), ex(0, 0, 0, 1, 1)}, both(ex(0, 0, 0, 0, 1)),
              both(ex(0, 0, 0, 1, 1)), both(ex(0, 0, 0, 1, 1)),
              {ex(0, 0, 0, 0, 1), ex(0, 0, 0, 1, 1)}, both(ex(0, 0, 0, 0, 1)),
              both(ex(0, 0, 0, 1, 1))};
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL shadow[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] x [4];
        logic [13:0] e;
        reset = 1'b0;
        drive(addu(17, 16, 16));
        sb.push_back(both(ex(0, 0, 1, 1, 0)));
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_mid got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        reset = 1'b1;
        x = '{both(ex(0, 0, 1, 1, 0)), both(ex(0, 0, 1, 1, 0)), both(ex(0, 0, 1, 1, 0)),
              both(ex(0, 0, 0, 0, 1))};
        for (int i = 0; i < 4; i++) begin
            drive(addu(17, 16, 16));
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL reset_mid_init[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_load_use();
        test_youngest();
        test_zero_and_imm();
        test_redirect();
        test_shadow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
